// File: rtl/dpcm_decoder_pkg.sv
// ============================================================================
// dpcm_decoder_pkg : shared DPCM constants, slot-state encoding, code helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package dpcm_decoder_pkg;

    localparam int CODE_W         = 4;
    localparam int SAMPLE_W_DEF   = 8;
    localparam int STEP_SH_DEF    = 2;
    localparam int FRAME_LEN_DEF  = 16;

    localparam logic [CODE_W-1:0] RESYNC_CODE = 4'b1000;

    // Output slot: EMPTY means nothing presented to the sink.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    function automatic logic is_resync(input logic [CODE_W-1:0] code);
        return (code == RESYNC_CODE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpcm_decoder_recon.sv
// ============================================================================
// dpcm_decoder_recon : combinational pred + (code <<< STEP_SH), wrap or clamp
// Config macro: DPCM_DEC_SAT_EN (defined = saturate, undefined = wrap)
// Revision 1.0
// ============================================================================
`default_nettype none

module dpcm_decoder_recon
    import dpcm_decoder_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int STEP_SH  = STEP_SH_DEF
) (
    input  logic [SAMPLE_W-1:0] pred_i,
    input  logic [CODE_W-1:0]   code_i,
    output logic [SAMPLE_W-1:0] sample_o
);

    logic signed [SAMPLE_W:0] w_diff;
    logic signed [SAMPLE_W:0] w_sum;

    // One guard bit above the sample width exposes overflow as MSB != MSB-1.
    assign w_diff = $signed({{(SAMPLE_W+1-CODE_W){code_i[CODE_W-1]}}, code_i}) <<< STEP_SH;
    assign w_sum  = $signed({pred_i[SAMPLE_W-1], pred_i}) + w_diff;

`ifdef DPCM_DEC_SAT_EN
    always_comb begin
        sample_o = w_sum[SAMPLE_W-1:0];
        if (w_sum[SAMPLE_W] != w_sum[SAMPLE_W-1]) begin
            sample_o = w_sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                       : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end
`else
    logic w_unused_msb;
    assign w_unused_msb = w_sum[SAMPLE_W];
    assign sample_o     = w_sum[SAMPLE_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/dpcm_decoder.sv
// ============================================================================
// dpcm_decoder : rebuilds signed PCM samples from a valid/ready DPCM code stream
// Config macro: DPCM_DEC_SAT_EN (saturating reconstruction when defined)
// Revision 1.0
// ============================================================================
`default_nettype none

module dpcm_decoder
    import dpcm_decoder_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int STEP_SH   = STEP_SH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                frame_start
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    slot_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                frame_start_q, frame_start_d;
    logic [SAMPLE_W-1:0] pred_q, pred_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                w_accept;
    logic                w_resync;
    logic                w_norm;
    logic                w_drain;
    logic [SAMPLE_W-1:0] w_sample;

    dpcm_decoder_recon #(
        .SAMPLE_W (SAMPLE_W),
        .STEP_SH  (STEP_SH)
    ) u_recon (
        .pred_i   (pred_q),
        .code_i   (data),
        .sample_o (w_sample)
    );

    assign out_valid   = (state_q == ST_FULL);
    assign in_ready    = !out_valid || out_ready;
    assign out_data    = out_data_q;
    assign frame_start = frame_start_q;

    assign w_accept = in_valid && in_ready;
    assign w_resync = is_resync(data);
    assign w_norm   = w_accept && !w_resync;
    assign w_drain  = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        frame_start_d = frame_start_q;
        pred_d        = pred_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            ST_EMPTY: if (w_norm) state_d = ST_FULL;
            ST_FULL: begin
                if (w_norm)       state_d = ST_FULL;
                else if (w_drain) state_d = ST_EMPTY;
            end
            default:              state_d = ST_EMPTY;
        endcase

        if (w_norm) begin
            out_data_d    = w_sample;
            frame_start_d = (cnt_q == '0);
            // Last sample of a frame is still emitted; only the predictor restarts.
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                pred_d = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                pred_d = w_sample;
            end
        end else if (w_accept) begin
            cnt_d  = '0;
            pred_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            out_data_q    <= '0;
            frame_start_q <= 1'b0;
            pred_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            frame_start_q <= frame_start_d;
            pred_q        <= pred_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dpcm_decoder.sv
// ============================================================================
// tb_dpcm_decoder : directed + random scoreboard bench for dpcm_decoder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dpcm_decoder;

    localparam int SAMPLE_W  = 8;
    localparam int STEP_SH   = 2;
    localparam int FRAME_LEN = 16;

    typedef struct {
        int d;
        bit fs;
    } samp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [3:0]          data = 4'd0;
    logic                out_ready = 1'b0;
    logic                in_ready;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_data;
    logic                frame_start;

    int    n_run  = 0;
    int    n_fail = 0;
    samp_t sb_q[$];
    samp_t got_q[$];
    int    m_pred = 0;
    int    m_cnt  = 0;

    always #5 clock = ~clock;

    dpcm_decoder #(
        .SAMPLE_W  (SAMPLE_W),
        .STEP_SH   (STEP_SH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data        (data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_start (frame_start)
    );

    function automatic int code_val(input logic [3:0] c);
        return c[3] ? int'(c) - 16 : int'(c);
    endfunction

    // Reference arithmetic: plain integers, then wrap or clamp into the sample range.
    function automatic int m_recon(input int p, input int c);
        int s;
        int m;
        m = 1 << SAMPLE_W;
        s = p + c * (1 << STEP_SH);
`ifdef DPCM_DEC_SAT_EN
        if (s > m/2 - 1) s = m/2 - 1;
        if (s < -(m/2))  s = -(m/2);
`else
        s = s % m;
        if (s < 0)      s += m;
        if (s >= m/2)   s -= m;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [3:0] c);
        int s;
        if (c == 4'b1000) begin
            m_pred = 0;
            m_cnt  = 0;
        end else begin
            s = m_recon(m_pred, code_val(c));
            sb_q.push_back('{d: s, fs: (m_cnt == 0)});
            if (m_cnt == FRAME_LEN - 1) begin
                m_cnt  = 0;
                m_pred = 0;
            end else begin
                m_cnt++;
                m_pred = s;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_pred = 0;
        m_cnt  = 0;
        sb_q.delete();
        got_q.delete();
    endtask

    // Presents one code until accepted; waited = cycles spent stalled.
    task automatic send(input logic [3:0] c, input bit rnd, output int waited);
        in_valid = 1'b1;
        data     = c;
        waited   = 0;
        for (int i = 0; i < 200; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (in_ready) begin
                model_accept(c);
                @(posedge clock); #1;
                in_valid = 1'b0;
                return;
            end
            waited++;
            @(posedge clock); #1;
        end
        n_run++;
        n_fail++;
        $display("FAIL send_timeout: code %0d never accepted", c);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        chk("drain_sb_empty", sb_q.size(), 0);
    endtask

    task automatic check_got(input string name, input int idx, input int d, input bit fs);
        if (idx >= got_q.size()) begin
            chk({name, "_count"}, got_q.size(), idx + 1);
        end else begin
            chk({name, "_data"}, got_q[idx].d, d);
            chk({name, "_fs"}, int'(got_q[idx].fs), int'(fs));
        end
    endtask

    // Monitor: every output transfer is popped against the scoreboard.
    initial begin
        samp_t e;
        int    a;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                a = int'($signed(out_data));
                got_q.push_back('{d: a, fs: frame_start});
                n_run++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0d fs %0b, expected nothing", a, frame_start);
                end else begin
                    e = sb_q.pop_front();
                    if (a != e.d || frame_start != e.fs) begin
                        n_fail++;
                        $display("FAIL sb_sample: got %0d fs %0b expected %0d fs %0b",
                                 a, frame_start, e.d, e.fs);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int last_exp;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clock); #1;

        // Basic reconstruction
        out_ready = 1'b1;
        repeat (3) send(4'd1, 1'b0, w);
        drain();
        check_got("t1_s0", 0, 4, 1'b1);
        check_got("t1_s1", 1, 8, 1'b0);
        check_got("t1_s2", 2, 12, 1'b0);

        // Overflow behaviour
        do_reset();
        repeat (5) send(4'd7, 1'b0, w);
        drain();
`ifdef DPCM_DEC_SAT_EN
        last_exp = 127;
`else
        last_exp = -116;
`endif
        check_got("t2_s3", 3, 112, 1'b0);
        check_got("t2_s4", 4, last_exp, 1'b0);

        // Backpressure holds the slot
        do_reset();
        out_ready = 1'b0;
        send(4'd5, 1'b0, w);
        repeat (4) begin
            @(negedge clock);
            chk("t3_in_ready", int'(in_ready), 0);
            chk("t3_out_valid", int'(out_valid), 1);
            chk("t3_out_data", int'($signed(out_data)), 20);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        send(4'd1, 1'b0, w);
        chk("t3_accept_wait", w, 0);
        drain();
        check_got("t3_s0", 0, 20, 1'b1);
        check_got("t3_s1", 1, 24, 1'b0);

        // RESYNC restarts predictor and frame
        do_reset();
        out_ready = 1'b1;
        send(4'd3, 1'b0, w);
        send(4'd3, 1'b0, w);
        send(4'b1000, 1'b0, w);
        send(4'd2, 1'b0, w);
        drain();
        chk("t4_count", got_q.size(), 3);
        check_got("t4_s1", 1, 24, 1'b0);
        check_got("t4_s2", 2, 8, 1'b1);

        // Frame boundary
        do_reset();
        repeat (FRAME_LEN + 1) send(4'd1, 1'b0, w);
        drain();
        check_got("t5_s0", 0, 4, 1'b1);
        check_got("t5_s15", 15, 64, 1'b0);
        check_got("t5_s16", 16, 4, 1'b1);

        // Reset discards a pending sample
        do_reset();
        out_ready = 1'b0;
        send(4'd3, 1'b0, w);
        do_reset();
        @(negedge clock);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_out_data", int'(out_data), 0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(4'd1, 1'b0, w);
        drain();
        check_got("t6_s0", 0, 4, 1'b1);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
            end
            send(4'($urandom_range(0, 15)), 1'b1, w);
        end
        drain();
        chk("rand_min_samples", int'(got_q.size() > 800), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
